// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
//   Shared definitions for the P7 multiply/divide unit sequencer.
//   - MDU operation encodings driven by the decoder into the E stage
//   - MIPS SPECIAL func codes for the MDU instructions (used by the decoder)
//   - Counter width and FSM state constants for mdu_ctrl
//   - Small helpers to classify an operation
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

    localparam int OP_W  = 4;
    localparam int CNT_W = 8;

    // Decoded E-stage MDU operation
    localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

    // SPECIAL-opcode func field values for the MDU instructions
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1a;
    localparam logic [5:0] FUNC_DIVU  = 6'h1b;

    // Sequencer states; RUN is the busy window
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Operations that open a busy window
    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // Operations that would change HI/LO or the sequencer state
    function automatic logic is_write_op(input logic [OP_W-1:0] op);
        return is_arith_op(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
//   Purely combinational arithmetic core of the MDU. The sequencer samples
//   these results on the accept edge and holds them until commit.
// Ports
//   op        in   4   decoded MDU op (selects signed vs unsigned)
//   rs_val    in   32  multiplicand / dividend
//   rt_val    in   32  multiplier / divisor
//   prod      out  64  32x32 product ({hi,lo})
//   quot      out  32  quotient, truncated toward zero
//   rem       out  32  remainder, sign follows the dividend
//   div0      out  1   divisor is zero (quot/rem meaningless)
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic [63:0]     prod,
    output logic [31:0]     quot,
    output logic [31:0]     rem,
    output logic            div0
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Signed division is done on magnitudes and then re-signed: quotient is
    // negative when operand signs differ, remainder takes the dividend's
    // sign. 0x80000000 / -1 falls out as 0x80000000 with remainder 0.
    // A zero divisor is replaced by 1 so the divider never sees x/0.
    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_ext     = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        b_ext     = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        prod      = a_ext * b_ext;

        a_neg  = is_signed & rs_val[31];
        b_neg  = is_signed & rt_val[31];
        a_mag  = a_neg ? (32'd0 - rs_val) : rs_val;
        b_mag  = b_neg ? (32'd0 - rt_val) : rt_val;
        div0   = (rt_val == 32'd0);
        b_safe = div0 ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
//   E-stage sequencer for the multiply/divide unit. Accepts one decoded MDU
//   op per cycle, runs mult/div as a fixed-latency busy window, commits HI/LO
//   at the end of it, serves mfhi/mflo/mthi/mtlo and asks the D stage to
//   hold MDU instructions while the unit is occupied.
// Ports
//   clk       in   1   pipeline clock
//   reset     in   1   synchronous active-high reset
//   mdu_op    in   4   decoded E-stage MDU op
//   flush     in   1   E-stage instruction squashed; its op is ignored
//   rs_val    in   32  forwarded rs operand
//   rt_val    in   32  forwarded rt operand
//   d_is_mdu  in   1   D-stage instruction is an MDU op
//   start     out  1   mult/div accepted this cycle (combinational)
//   busy      out  1   operation in flight (registered)
//   hi        out  32  architectural HI
//   lo        out  32  architectural LO
//   rdata     out  32  mfhi/mflo read data (combinational)
//   stall_d   out  1   hold the D-stage MDU instruction
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] mdu_op,
    input  logic            flush,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic            d_is_mdu,
    output logic            start,
    output logic            busy,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic [31:0]     rdata,
    output logic            stall_d
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pending_hi_q, pending_hi_d;
    logic [31:0]      pending_lo_q, pending_lo_d;
    logic             pending_wr_q, pending_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      prod;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic             div0;
    logic             is_mult;

    mdu_arith u_arith (
        .op     (mdu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem),
        .div0   (div0)
    );

    // The result is captured at accept time, so operand forwarding only has
    // to be valid for the start cycle. pending_wr records whether the commit
    // should touch HI/LO at all (a divide by zero leaves them untouched but
    // still occupies the full window).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_wr_d = pending_wr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        is_mult = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
        start   = (state_q == ST_IDLE) && !flush && is_arith_op(mdu_op);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    cnt_d        = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    pending_hi_d = is_mult ? prod[63:32] : rem;
                    pending_lo_d = is_mult ? prod[31:0]  : quot;
                    pending_wr_d = is_mult || !div0;
                end else if (!flush) begin
                    if (mdu_op == MDU_MTHI) hi_d = rs_val;
                    if (mdu_op == MDU_MTLO) lo_d = rs_val;
                end
            end
            ST_RUN: begin
                // Ops arriving here are illegal and deliberately ignored
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pending_wr_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All sequencer state, including in-flight results, is cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pending_hi_q <= '0;
            pending_lo_q <= '0;
            pending_wr_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_wr_q <= pending_wr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // mfhi/mflo during RUN return the old value; the hazard unit keeps such
    // a read from ever committing
    always_comb begin
        busy    = (state_q == ST_RUN);
        hi      = hi_q;
        lo      = lo_q;
        stall_d = d_is_mdu && (start || busy);
        if (mdu_op == MDU_MFHI)      rdata = hi_q;
        else if (mdu_op == MDU_MFLO) rdata = lo_q;
        else                         rdata = 32'd0;
    end

    // A state-changing MDU op must never reach E while the unit is busy
    a_no_op_while_busy: assert property (
        @(posedge clk) disable iff (reset)
        (busy && !flush) |-> !is_write_op(mdu_op)
    );

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
//   Directed self-checking bench for mdu_ctrl. Inputs change 1 time unit
//   after the rising edge and outputs are sampled 2 units later.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic            clk;
    logic            reset;
    logic [OP_W-1:0] mdu_op;
    logic            flush;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    logic            d_is_mdu;
    logic            start;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic [31:0]     rdata;
    logic            stall_d;

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [31:0] cur_hi    = 32'd0;
    logic [31:0] cur_lo    = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .mdu_op   (mdu_op),
        .flush    (flush),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_mdu (d_is_mdu),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata),
        .stall_d  (stall_d)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison and mismatch reporting
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl, input logic dm);
        mdu_op   = op;
        rs_val   = a;
        rt_val   = b;
        flush    = fl;
        d_is_mdu = dm;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Start op in the current cycle, walk the n busy cycles, then check the
    // committed HI/LO in the first idle cycle (left there for the caller)
    task automatic runOp(input string tag, input logic [OP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(op, a, b, 1'b0, 1'b1);
        settle();
        checkOutput({tag, ".start"}, 32'(start), 32'd1);
        checkOutput({tag, ".stall0"}, 32'(stall_d), 32'd1);
        nextCycle();
        for (int i = 1; i <= n; i++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
            settle();
            checkOutput($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s.stall%0d", tag, i), 32'(stall_d), 32'd1);
            checkOutput($sformatf("%s.oldhi%0d", tag, i), hi, cur_hi);
            nextCycle();
        end
        applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        settle();
        checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".nostall"}, 32'(stall_d), 32'd0);
        checkOutput({tag, ".hi"}, hi, exp_hi);
        checkOutput({tag, ".lo"}, lo, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        settle();
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.hi", hi, 32'd0);
        checkOutput("rst.lo", lo, 32'd0);
        checkOutput("rst.start", 32'(start), 32'd0);
        checkOutput("rst.stall", 32'(stall_d), 32'd0);
        nextCycle();

        // -2 * 3 = -6
        runOp("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        applyStimulus(MDU_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
        settle();
        checkOutput("mfhi.rdata", rdata, 32'hFFFFFFFF);
        checkOutput("mfhi.stall", 32'(stall_d), 32'd0);
        applyStimulus(MDU_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);
        settle();
        checkOutput("mflo.rdata", rdata, 32'hFFFFFFFA);
        nextCycle();

        // -7 / 2 = -3 rem -1, then MULTU accepted on the first idle cycle
        runOp("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("b2b_multu", MDU_MULTU, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0);
        nextCycle();

        // Divide by zero leaves HI/LO alone after the full window
        runOp("divu0", MDU_DIVU, 32'd7, 32'd0, 10, 32'd1, 32'd0);
        nextCycle();
        runOp("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        nextCycle();
        runOp("div_neg", MDU_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        nextCycle();
        runOp("divu", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        nextCycle();
        runOp("mult_m1", MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'd0, 32'd1);
        nextCycle();

        // MTHI squashed, then taken
        applyStimulus(MDU_MTHI, 32'h12345678, 32'd0, 1'b1, 1'b1);
        settle();
        checkOutput("mthi_fl.start", 32'(start), 32'd0);
        nextCycle();
        applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        checkOutput("mthi_fl.hi", hi, 32'd0);
        applyStimulus(MDU_MTHI, 32'h12345678, 32'd0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(MDU_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
        settle();
        checkOutput("mthi.hi", hi, 32'h12345678);
        checkOutput("mthi.rdata", rdata, 32'h12345678);
        applyStimulus(MDU_MTLO, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(MDU_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);
        settle();
        checkOutput("mtlo.rdata", rdata, 32'hCAFEF00D);

        // Squashed MULT must not start
        applyStimulus(MDU_MULT, 32'd3, 32'd5, 1'b1, 1'b1);
        settle();
        checkOutput("mult_fl.start", 32'(start), 32'd0);
        nextCycle();
        applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        checkOutput("mult_fl.busy", 32'(busy), 32'd0);
        nextCycle();

        // Reset in busy cycle 3 aborts the MULT
        applyStimulus(MDU_MULT, 32'd3, 32'd5, 1'b0, 1'b1);
        settle();
        checkOutput("rstrun.start", 32'(start), 32'd1);
        nextCycle();
        applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        settle();
        checkOutput("rstrun.busy3", 32'(busy), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        settle();
        checkOutput("rstrun.busy", 32'(busy), 32'd0);
        checkOutput("rstrun.hi", hi, 32'd0);
        checkOutput("rstrun.lo", lo, 32'd0);
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            settle();
            checkOutput($sformatf("rstrun.late_hi%0d", i), hi, 32'd0);
            checkOutput($sformatf("rstrun.late_lo%0d", i), lo, 32'd0);
            checkOutput($sformatf("rstrun.late_busy%0d", i), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
